// File: rtl/mnist_pkg.sv
// Shared widths, defaults and helpers for the MNIST class-vote block.
// No logic here; everything is compile-time.
// Consumers derive their own widths from their parameters with clog2.
package mnist_pkg;

  localparam int DEF_CLASS_NUM   = 10;
  localparam int DEF_CHANNEL_NUM = 8;

  // Ceiling log2, with clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  localparam int CNT_W = clog2(DEF_CHANNEL_NUM + 1);
  localparam int IDX_W = clog2(DEF_CLASS_NUM);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/mnist_argmax_stage.sv
// One registered level of the argmax tree: pairs (2k, 2k+1) reduce to one entry.
// Latency 1 cke-qualified cycle; user/label/valid are delayed alongside.
// No backpressure: every enabled cycle accepts a new beat.
module mnist_argmax_stage #(
  parameter int IN_NUM      = 10,
  parameter int CNT_W       = 4,
  parameter int IDX_W       = 4,
  parameter int USER_WIDTH  = 9,
  parameter int LABEL_WIDTH = 8,
  localparam int OUT_NUM    = (IN_NUM + 1) / 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cke,
  input  logic [IN_NUM*CNT_W-1:0]  in_cnt,
  input  logic [IN_NUM*IDX_W-1:0]  in_idx,
  input  logic [USER_WIDTH-1:0]    in_user,
  input  logic [LABEL_WIDTH-1:0]   in_label,
  input  logic                     in_valid,
  output logic [OUT_NUM*CNT_W-1:0] out_cnt,
  output logic [OUT_NUM*IDX_W-1:0] out_idx,
  output logic [USER_WIDTH-1:0]    out_user,
  output logic [LABEL_WIDTH-1:0]   out_label,
  output logic                     out_valid,
  output logic                     out_none,
  output logic                     out_match
);

  localparam int PAD_CNT_W = 2 * OUT_NUM * CNT_W;
  localparam int PAD_IDX_W = 2 * OUT_NUM * IDX_W;

  // An odd leftover entry is paired with a zero-count dummy; since the right
  // side only wins when strictly greater, the leftover passes through as-is.
  logic [PAD_CNT_W-1:0]     cnt_pad;
  logic [PAD_IDX_W-1:0]     idx_pad;
  logic [OUT_NUM*CNT_W-1:0] cnt_nxt;
  logic [OUT_NUM*IDX_W-1:0] idx_nxt;
  logic [CNT_W-1:0]         win_cnt;
  logic [IDX_W-1:0]         win_idx;

  assign cnt_pad = PAD_CNT_W'(in_cnt);
  assign idx_pad = PAD_IDX_W'(in_idx);

  // Pairwise compare; ties keep the left (lower-index) candidate.
  always_comb begin
    cnt_nxt = '0;
    idx_nxt = '0;
    for (int k = 0; k < OUT_NUM; k++) begin
      if (cnt_pad[(2*k+1)*CNT_W +: CNT_W] > cnt_pad[2*k*CNT_W +: CNT_W]) begin
        cnt_nxt[k*CNT_W +: CNT_W] = cnt_pad[(2*k+1)*CNT_W +: CNT_W];
        idx_nxt[k*IDX_W +: IDX_W] = idx_pad[(2*k+1)*IDX_W +: IDX_W];
      end else begin
        cnt_nxt[k*CNT_W +: CNT_W] = cnt_pad[2*k*CNT_W +: CNT_W];
        idx_nxt[k*IDX_W +: IDX_W] = idx_pad[2*k*IDX_W +: IDX_W];
      end
    end
  end

  // Entry 0 is the overall winner once the level has a single output.
  assign win_cnt = cnt_nxt[CNT_W-1:0];
  assign win_idx = idx_nxt[IDX_W-1:0];

  // Level registers, frozen while cke is low; reset overrides cke.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_cnt   <= '0;
      out_idx   <= '0;
      out_user  <= '0;
      out_label <= '0;
      out_valid <= 1'b0;
      out_none  <= 1'b0;
      out_match <= 1'b0;
    end else if (cke) begin
      out_cnt   <= cnt_nxt;
      out_idx   <= idx_nxt;
      out_user  <= in_user;
      out_label <= in_label;
      out_valid <= in_valid;
      out_none  <= (win_cnt == '0);
      out_match <= (win_cnt != '0) &&
                   ({{LABEL_WIDTH{1'b0}}, win_idx} == {{IDX_W{1'b0}}, in_label});
    end
  end

endmodule

// File: rtl/mnist_class_vote.sv
// Per-class channel popcount, argmax tree, label compare and accuracy counters.
// Latency 1 + clog2(CLASS_NUM) cke-qualified cycles (5 for 10 classes), 1 beat/cycle.
// No backpressure; cke low stalls the whole pipeline and the counters.
module mnist_class_vote
  import mnist_pkg::*;
#(
  parameter int CLASS_NUM   = DEF_CLASS_NUM,
  parameter int CHANNEL_NUM = DEF_CHANNEL_NUM,
  parameter int USER_WIDTH  = 9,
  parameter int LABEL_WIDTH = 8,
  localparam int CNT_BITS   = clog2(CHANNEL_NUM + 1),
  localparam int IDX_BITS   = clog2(CLASS_NUM)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cke,
  input  logic [USER_WIDTH-1:0]          in_user,
  input  logic [LABEL_WIDTH-1:0]         in_label,
  input  logic [CLASS_NUM*CHANNEL_NUM-1:0] in_data,
  input  logic                           in_valid,
  output logic [USER_WIDTH-1:0]          out_user,
  output logic [IDX_BITS-1:0]            out_class,
  output logic [CNT_BITS-1:0]            out_count,
  output logic                           out_none,
  output logic                           out_match,
  output logic                           out_valid,
  input  logic                           stat_clear,
  output logic [31:0]                    stat_total,
  output logic [31:0]                    stat_ok
);

  localparam int DEPTH = clog2(CLASS_NUM);

  logic [CLASS_NUM*CNT_BITS-1:0] pop_nxt;
  logic [CLASS_NUM*CNT_BITS-1:0] pop_q;
  logic [CLASS_NUM*IDX_BITS-1:0] idx_init;
  logic [LABEL_WIDTH-1:0]        label_q;
  logic [USER_WIDTH-1:0]         user_q;
  logic                          valid_q;

  // Count how many channels voted for each class.
  always_comb begin
    pop_nxt = '0;
    for (int i = 0; i < CLASS_NUM; i++) begin
      for (int j = 0; j < CHANNEL_NUM; j++) begin
        pop_nxt[i*CNT_BITS +: CNT_BITS] = pop_nxt[i*CNT_BITS +: CNT_BITS] +
                                          CNT_BITS'(in_data[j*CLASS_NUM+i]);
      end
    end
  end

  // Stage 0: popcounts plus the sideband that travels with them.
  always_ff @(posedge clk) begin
    if (reset) begin
      pop_q   <= '0;
      label_q <= '0;
      user_q  <= '0;
      valid_q <= 1'b0;
    end else if (cke) begin
      pop_q   <= pop_nxt;
      label_q <= in_label;
      user_q  <= in_user;
      valid_q <= in_valid;
    end
  end

  // Leaf indices are simply the class numbers.
  for (genvar i = 0; i < CLASS_NUM; i++) begin : g_idx
    assign idx_init[i*IDX_BITS +: IDX_BITS] = IDX_BITS'(i);
  end

  // Tree levels: level l reduces ceil(CLASS_NUM/2^l) entries to half that.
  for (genvar l = 0; l < DEPTH; l++) begin : g_lvl
    localparam int IN_N  = (CLASS_NUM + (1 << l) - 1) >> l;
    localparam int OUT_N = (IN_N + 1) / 2;

    logic [OUT_N*CNT_BITS-1:0] cnt;
    logic [OUT_N*IDX_BITS-1:0] idx;
    logic [USER_WIDTH-1:0]     user;
    logic [LABEL_WIDTH-1:0]    label;
    logic                      valid;
    logic                      none;
    logic                      match;

    if (l == 0) begin : g_head
      mnist_argmax_stage #(
        .IN_NUM(IN_N), .CNT_W(CNT_BITS), .IDX_W(IDX_BITS),
        .USER_WIDTH(USER_WIDTH), .LABEL_WIDTH(LABEL_WIDTH)
      ) u_stage (
        .clk(clk), .reset(reset), .cke(cke),
        .in_cnt(pop_q), .in_idx(idx_init), .in_user(user_q),
        .in_label(label_q), .in_valid(valid_q),
        .out_cnt(cnt), .out_idx(idx), .out_user(user), .out_label(label),
        .out_valid(valid), .out_none(none), .out_match(match)
      );
    end else begin : g_body
      mnist_argmax_stage #(
        .IN_NUM(IN_N), .CNT_W(CNT_BITS), .IDX_W(IDX_BITS),
        .USER_WIDTH(USER_WIDTH), .LABEL_WIDTH(LABEL_WIDTH)
      ) u_stage (
        .clk(clk), .reset(reset), .cke(cke),
        .in_cnt(g_lvl[l-1].cnt), .in_idx(g_lvl[l-1].idx), .in_user(g_lvl[l-1].user),
        .in_label(g_lvl[l-1].label), .in_valid(g_lvl[l-1].valid),
        .out_cnt(cnt), .out_idx(idx), .out_user(user), .out_label(label),
        .out_valid(valid), .out_none(none), .out_match(match)
      );
    end

    // Only the last level's none/match are meaningful; its label has no consumer.
    if (l == DEPTH - 1) begin : g_tail
      logic unused_label;
      assign unused_label = ^label;
      assign out_class    = idx;
      assign out_count    = cnt;
      assign out_user     = user;
      assign out_valid    = valid;
      assign out_none     = none;
      assign out_match    = match;
    end else begin : g_mid
      logic unused_flags;
      assign unused_flags = none ^ match;
    end
  end

  // Accuracy counters: clear beats a coincident result, both saturate.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_total <= '0;
      stat_ok    <= '0;
    end else if (cke) begin
      if (stat_clear) begin
        stat_total <= '0;
        stat_ok    <= '0;
      end else if (out_valid) begin
        if (stat_total != 32'hFFFF_FFFF) stat_total <= stat_total + 32'd1;
        if (out_match && stat_ok != 32'hFFFF_FFFF) stat_ok <= stat_ok + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_mnist_class_vote.sv
// Directed bench for mnist_class_vote: results, ties, empty votes, stalls,
// mid-stream reset, counter clear and saturation.
module tb_mnist_class_vote;
  import mnist_pkg::*;

  localparam int DATA_W = DEF_CLASS_NUM * DEF_CHANNEL_NUM;

  logic              clk;
  logic              reset;
  logic              cke;
  logic [8:0]        in_user;
  logic [7:0]        in_label;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic [8:0]        out_user;
  idx_t              out_class;
  cnt_t              out_count;
  logic              out_none;
  logic              out_match;
  logic              out_valid;
  logic              stat_clear;
  logic [31:0]       stat_total;
  logic [31:0]       stat_ok;

  int checks;
  int passed;

  mnist_class_vote dut (
    .clk(clk), .reset(reset), .cke(cke),
    .in_user(in_user), .in_label(in_label), .in_data(in_data), .in_valid(in_valid),
    .out_user(out_user), .out_class(out_class), .out_count(out_count),
    .out_none(out_none), .out_match(out_match), .out_valid(out_valid),
    .stat_clear(stat_clear), .stat_total(stat_total), .stat_ok(stat_ok)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Channels 0..n-1 vote for class cls.
  function automatic logic [DATA_W-1:0] votes(input int cls, input int n);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int j = 0; j < n; j++) v[j*DEF_CLASS_NUM+cls] = 1'b1;
    return v;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Present one valid beat for one edge, then idle.
  task automatic apply(input logic [DATA_W-1:0] d, input logic [7:0] l, input logic [8:0] u);
    in_data  = d;
    in_label = l;
    in_user  = u;
    in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cke = 1'b0; stat_clear = 1'b0;
    in_valid = 1'b1; in_data = '1; in_label = 8'd0; in_user = 9'h1FF;
    step(2);
    checks++;
    if ({out_valid, out_class, out_count, out_none, out_match} !== 11'd0) begin
      $display("FAIL reset_outputs: got %b want 0", {out_valid, out_class, out_count, out_none, out_match});
    end else passed++;
    checks++;
    if (out_user !== 9'd0) $display("FAIL reset_user: got %h want 000", out_user);
    else passed++;
    checks++;
    if ({stat_total, stat_ok} !== 64'd0) $display("FAIL reset_stats: got %h/%h want 0/0", stat_total, stat_ok);
    else passed++;
    reset = 1'b0; cke = 1'b1; in_valid = 1'b0; in_data = '0; in_user = 9'd0;
    step(1);
  endtask

  task automatic test_single();
    apply(votes(3, 8), 8'd3, 9'h155);
    step(3);
    checks++;
    if (out_valid !== 1'b0) $display("FAIL single_early: out_valid got %b want 0 after 4 edges", out_valid);
    else passed++;
    step(1);
    checks++;
    if ({out_valid, out_class, out_count, out_none, out_match} !== {1'b1, 4'd3, 4'd8, 1'b0, 1'b1}) begin
      $display("FAIL single_result: v/cls/cnt/none/match got %b/%0d/%0d/%b/%b want 1/3/8/0/1",
               out_valid, out_class, out_count, out_none, out_match);
    end else passed++;
    checks++;
    if (out_user !== 9'h155) $display("FAIL single_user: got %h want 155", out_user);
    else passed++;
    step(1);
    checks++;
    if ({stat_total, stat_ok} !== {32'd1, 32'd1}) $display("FAIL single_stats: got %0d/%0d want 1/1", stat_total, stat_ok);
    else passed++;
  endtask

  task automatic test_tie();
    apply(votes(2, 5) | votes(7, 5), 8'd7, 9'h0A7);
    step(4);
    checks++;
    if ({out_valid, out_class, out_count, out_none, out_match} !== {1'b1, 4'd2, 4'd5, 1'b0, 1'b0}) begin
      $display("FAIL tie_result: v/cls/cnt/none/match got %b/%0d/%0d/%b/%b want 1/2/5/0/0",
               out_valid, out_class, out_count, out_none, out_match);
    end else passed++;
    step(1);
    checks++;
    if ({stat_total, stat_ok} !== {32'd2, 32'd1}) $display("FAIL tie_stats: got %0d/%0d want 2/1", stat_total, stat_ok);
    else passed++;
  endtask

  task automatic test_none();
    apply('0, 8'd0, 9'h100);
    step(4);
    checks++;
    if ({out_valid, out_class, out_count, out_none, out_match} !== {1'b1, 4'd0, 4'd0, 1'b1, 1'b0}) begin
      $display("FAIL none_result: v/cls/cnt/none/match got %b/%0d/%0d/%b/%b want 1/0/0/1/0",
               out_valid, out_class, out_count, out_none, out_match);
    end else passed++;
    step(1);
    checks++;
    if ({stat_total, stat_ok} !== {32'd3, 32'd1}) $display("FAIL none_stats: got %0d/%0d want 3/1", stat_total, stat_ok);
    else passed++;
  endtask

  // Class 9 is the odd leftover at two tree levels and must still win.
  task automatic test_leftover();
    apply(votes(9, 6) | votes(0, 5) | votes(8, 3), 8'd9, 9'h009);
    step(4);
    checks++;
    if ({out_valid, out_class, out_count, out_none, out_match} !== {1'b1, 4'd9, 4'd6, 1'b0, 1'b1}) begin
      $display("FAIL leftover_result: v/cls/cnt/none/match got %b/%0d/%0d/%b/%b want 1/9/6/0/1",
               out_valid, out_class, out_count, out_none, out_match);
    end else passed++;
    step(1);
    checks++;
    if ({stat_total, stat_ok} !== {32'd4, 32'd2}) $display("FAIL leftover_stats: got %0d/%0d want 4/2", stat_total, stat_ok);
    else passed++;
  endtask

  // Beat i: class i%10 with 1+i%8 votes, label matches when i%3==0, user = i.
  task automatic test_back_to_back();
    int sent, got, ecount, cyc;
    int exp_edge [100];
    logic [83:0] snap, now_v;
    logic ck;
    logic [20:0] exp_v;
    sent = 0; got = 0; ecount = 0; cyc = 0;
    snap = {out_valid, out_class, out_count, out_none, out_match, out_user, stat_total, stat_ok};
    while (got < 100 && cyc < 1000) begin
      ck  = ($urandom_range(0, 3) != 0);
      cke = ck;
      if (sent < 100) begin
        in_data  = votes(sent % 10, 1 + sent % 8);
        in_label = (sent % 3 == 0) ? 8'(sent % 10) : 8'((sent % 10 + 1) % 10);
        in_user  = 9'(sent);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
        in_data  = '0;
      end
      @(posedge clk);
      if (ck) begin
        if (sent < 100) begin
          exp_edge[sent] = ecount + 4;
          sent++;
        end
        ecount++;
      end
      @(negedge clk);
      now_v = {out_valid, out_class, out_count, out_none, out_match, out_user, stat_total, stat_ok};
      if (!ck) begin
        checks++;
        if (now_v !== snap) $display("FAIL b2b_hold: cyc %0d got %h want %h", cyc, now_v, snap);
        else passed++;
      end else if (out_valid) begin
        checks++;
        if (got >= 100) begin
          $display("FAIL b2b_extra: unexpected out_valid got 1 want 0");
        end else begin
          exp_v = {4'(got % 10), 4'(1 + got % 8), 1'b0, (got % 3 == 0), 9'(got), 2'b00};
          if ({out_class, out_count, out_none, out_match, out_user, 2'b00} !== exp_v) begin
            $display("FAIL b2b_data: beat %0d got %h want %h", got,
                     {out_class, out_count, out_none, out_match, out_user, 2'b00}, exp_v);
          end else if (ecount - 1 != exp_edge[got]) begin
            $display("FAIL b2b_latency: beat %0d got edge %0d want %0d", got, ecount - 1, exp_edge[got]);
          end else passed++;
        end
        got++;
      end
      snap = now_v;
      cyc++;
    end
    cke = 1'b1;
    in_valid = 1'b0;
    checks++;
    if (got != 100) $display("FAIL b2b_timeout: got %0d results want 100", got);
    else passed++;
    step(2);
    checks++;
    if ({stat_total, stat_ok} !== {32'd104, 32'd36}) $display("FAIL b2b_stats: got %0d/%0d want 104/36", stat_total, stat_ok);
    else passed++;
  endtask

  // Reset with cke low while three beats are in flight.
  task automatic test_reset_midstream();
    in_data = votes(4, 7); in_label = 8'd4; in_user = 9'h044; in_valid = 1'b1;
    step(3);
    in_valid = 1'b0;
    cke = 1'b0;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    cke = 1'b1;
    checks++;
    if ({out_valid, stat_total, stat_ok} !== 65'd0) $display("FAIL midreset_clear: v/total/ok got %b/%0d/%0d want 0/0/0", out_valid, stat_total, stat_ok);
    else passed++;
    apply(votes(5, 4), 8'd5, 9'h055);
    for (int k = 2; k <= 5; k++) begin
      step(1);
      checks++;
      if (k < 5) begin
        if (out_valid !== 1'b0) $display("FAIL midreset_flush: edge %0d out_valid got %b want 0", k, out_valid);
        else passed++;
      end else begin
        if ({out_valid, out_class, out_count, out_user} !== {1'b1, 4'd5, 4'd4, 9'h055})
          $display("FAIL midreset_first: v/cls/cnt/user got %b/%0d/%0d/%h want 1/5/4/055", out_valid, out_class, out_count, out_user);
        else passed++;
      end
    end
    step(1);
    checks++;
    if ({stat_total, stat_ok} !== {32'd1, 32'd1}) $display("FAIL midreset_stats: got %0d/%0d want 1/1", stat_total, stat_ok);
    else passed++;
  endtask

  task automatic test_stat_clear();
    apply(votes(1, 3), 8'd1, 9'h011);
    apply(votes(6, 2), 8'd6, 9'h066);
    step(3);
    checks++;
    if ({out_valid, out_class} !== {1'b1, 4'd1}) $display("FAIL clear_first: v/cls got %b/%0d want 1/1", out_valid, out_class);
    else passed++;
    step(1);
    checks++;
    if ({out_valid, out_class, out_match, stat_total, stat_ok} !== {1'b1, 4'd6, 1'b1, 32'd2, 32'd2})
      $display("FAIL clear_pre: v/cls/match/total/ok got %b/%0d/%b/%0d/%0d want 1/6/1/2/2", out_valid, out_class, out_match, stat_total, stat_ok);
    else passed++;
    stat_clear = 1'b1;
    step(1);
    stat_clear = 1'b0;
    checks++;
    if ({stat_total, stat_ok} !== 64'd0) $display("FAIL clear_wins: got %0d/%0d want 0/0", stat_total, stat_ok);
    else passed++;
    step(1);
    checks++;
    if ({stat_total, stat_ok} !== 64'd0) $display("FAIL clear_after: got %0d/%0d want 0/0", stat_total, stat_ok);
    else passed++;
  endtask

  task automatic test_saturation();
    force dut.stat_total = 32'hFFFF_FFFE;
    force dut.stat_ok    = 32'hFFFF_FFFE;
    #1;
    release dut.stat_total;
    release dut.stat_ok;
    apply(votes(8, 8), 8'd8, 9'h088);
    apply(votes(2, 1), 8'd2, 9'h022);
    step(4);
    checks++;
    if ({stat_total, stat_ok} !== {32'hFFFF_FFFF, 32'hFFFF_FFFF}) $display("FAIL sat_reach: got %h/%h want ffffffff/ffffffff", stat_total, stat_ok);
    else passed++;
    step(1);
    checks++;
    if ({stat_total, stat_ok} !== {32'hFFFF_FFFF, 32'hFFFF_FFFF}) $display("FAIL sat_hold: got %h/%h want ffffffff/ffffffff", stat_total, stat_ok);
    else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_single();
    test_tie();
    test_none();
    test_leftover();
    test_back_to_back();
    test_reset_midstream();
    test_stat_clear();
    test_saturation();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
